// File: rtl/risc16_mem_responder.sv
// Data-side responder for the risc16 core: SRAM accesses take WAIT_STATES+1 halted cycles plus one DONE cycle.
// I/O at IO_ADDR is zero-wait. The core is stalled through combinational cpu_halt, and it has no other backpressure.
module risc16_mem_responder #(
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_rw,
  output logic        cpu_halt,
  output logic [15:0] cpu_rdata,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  input  logic [15:0] io_in,
  output logic [15:0] io_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic       rw_q;
  logic       io_sel;
  logic       sram_go;
  logic       io_go;

  assign io_sel = (cpu_addr == IO_ADDR);

  always_comb begin
    state_nxt = state;
    cpu_halt  = 1'b0;
    sram_go   = 1'b0;
    io_go     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (io_sel) begin
            io_go = 1'b1;
          end else begin
            sram_go   = 1'b1;
            cpu_halt  = 1'b1;
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        cpu_halt = 1'b1;
        if (wait_cnt == 4'd0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // The core must see no stall while reset is applied, even mid-access.
    if (rst) cpu_halt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata  <= 16'h0000;
      sram_addr  <= 16'h0000;
      sram_wdata <= 16'h0000;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      io_out     <= 16'h0000;
      wait_cnt   <= 4'd0;
      rw_q       <= 1'b0;
    end else begin
      if (sram_go) begin
        sram_addr  <= cpu_addr;
        sram_wdata <= cpu_wdata;
        rw_q       <= cpu_rw;
        sram_ce_n  <= 1'b0;
        sram_oe_n  <= cpu_rw;
        sram_we_n  <= ~cpu_rw;
        wait_cnt   <= CNT_INIT;
      end else if (state == ACCESS) begin
        if (wait_cnt == 4'd0) begin
          if (!rw_q) cpu_rdata <= sram_rdata;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt - 4'd1;
        end
      end
      if (io_go) begin
        if (cpu_rw) io_out    <= cpu_wdata;
        else        cpu_rdata <= io_in;
      end
    end
  end

endmodule

// File: tb/tb_risc16_mem_responder.sv
// Bench for risc16_mem_responder: WAIT_STATES=2 and WAIT_STATES=1 builds share one stimulus stream,
// and each build is checked every cycle against a timeline model.
module tb_risc16_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_rw;
  logic [15:0] sram_rdata;
  logic [15:0] io_in;

  logic        halt2, ce2, oe2, we2, halt1, ce1, oe1, we1;
  logic [15:0] rd2, sa2, sw2, io2, rd1, sa1, sw1, io1;

  always #5 clk = ~clk;

  risc16_mem_responder #(.WAIT_STATES(2), .IO_ADDR(16'hFFFF)) dut2 (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rw(cpu_rw), .cpu_halt(halt2), .cpu_rdata(rd2), .sram_addr(sa2), .sram_wdata(sw2),
    .sram_rdata(sram_rdata), .sram_ce_n(ce2), .sram_oe_n(oe2), .sram_we_n(we2),
    .io_in(io_in), .io_out(io2));

  risc16_mem_responder #(.WAIT_STATES(1), .IO_ADDR(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rw(cpu_rw), .cpu_halt(halt1), .cpu_rdata(rd1), .sram_addr(sa1), .sram_wdata(sw1),
    .sram_rdata(sram_rdata), .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1),
    .io_in(io_in), .io_out(io1));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted SRAM request at cycle t0 halts cycles t0..t0+ws, drives strobes in
  // cycles t0+1..t0+ws, captures load data at the end of t0+ws and idles after t0+ws+1.
  int          cyc = 0;
  bit          m_busy [2];
  int          m_t0   [2];
  logic        m_rw   [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_wd   [2];
  logic [15:0] m_rd   [2];
  logic [15:0] m_io   [2];
  int          m_ws, m_k;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0; m_t0[i] = 0; m_rw[i] = 1'b0;
        m_addr[i] = 16'h0; m_wd[i] = 16'h0; m_rd[i] = 16'h0; m_io[i] = 16'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_ws = (i == 0) ? 2 : 1;
        if (!m_busy[i]) begin
          if (cpu_req) begin
            if (cpu_addr == 16'hFFFF) begin
              if (cpu_rw) m_io[i] = cpu_wdata;
              else        m_rd[i] = io_in;
            end else begin
              m_busy[i] = 1'b1; m_t0[i] = cyc; m_rw[i] = cpu_rw;
              m_addr[i] = cpu_addr; m_wd[i] = cpu_wdata;
            end
          end
        end else begin
          m_k = cyc - m_t0[i];
          if (m_k == m_ws && !m_rw[i]) m_rd[i] = sram_rdata;
          if (m_k == m_ws + 1) m_busy[i] = 1'b0;
        end
      end
      cyc++;
    end
  end

  int hc[2], oc[2], wc[2];
  logic        e_halt, e_ce, e_oe, e_we;
  logic        a_halt, a_ce, a_oe, a_we;
  logic [15:0] a_rd, a_sa, a_sw, a_io;
  int          c_ws, c_k;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      c_ws = (i == 0) ? 2 : 1;
      a_halt = (i == 0) ? halt2 : halt1;
      a_ce   = (i == 0) ? ce2 : ce1;
      a_oe   = (i == 0) ? oe2 : oe1;
      a_we   = (i == 0) ? we2 : we1;
      a_rd   = (i == 0) ? rd2 : rd1;
      a_sa   = (i == 0) ? sa2 : sa1;
      a_sw   = (i == 0) ? sw2 : sw1;
      a_io   = (i == 0) ? io2 : io1;
      e_halt = 1'b0; e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1;
      if (!rst) begin
        if (!m_busy[i]) begin
          e_halt = cpu_req && (cpu_addr != 16'hFFFF);
        end else begin
          c_k = cyc - m_t0[i];
          if (c_k <= c_ws) begin
            e_halt = 1'b1; e_ce = 1'b0; e_oe = m_rw[i]; e_we = ~m_rw[i];
          end
        end
      end
      chk($sformatf("ws%0d halt", c_ws), {15'h0, a_halt}, {15'h0, e_halt});
      chk($sformatf("ws%0d ce_n", c_ws), {15'h0, a_ce},   {15'h0, e_ce});
      chk($sformatf("ws%0d oe_n", c_ws), {15'h0, a_oe},   {15'h0, e_oe});
      chk($sformatf("ws%0d we_n", c_ws), {15'h0, a_we},   {15'h0, e_we});
      chk($sformatf("ws%0d rdata", c_ws), a_rd, m_rd[i]);
      chk($sformatf("ws%0d sram_addr", c_ws), a_sa, m_addr[i]);
      chk($sformatf("ws%0d sram_wdata", c_ws), a_sw, m_wd[i]);
      chk($sformatf("ws%0d io_out", c_ws), a_io, m_io[i]);
      if (a_halt) hc[i]++;
      if (!a_oe)  oc[i]++;
      if (!a_we)  wc[i]++;
    end
  end

  task automatic clr_cnt();
    for (int i = 0; i < 2; i++) begin
      hc[i] = 0; oc[i] = 0; wc[i] = 0;
    end
  endtask

  // Present a request pattern for n cycles, returning just after the last edge.
  task automatic drive(input logic req, input logic [15:0] a, input logic [15:0] d,
                       input logic rw, input int n);
    cpu_req = req; cpu_addr = a; cpu_wdata = d; cpu_rw = rw;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h0;
    cpu_rw = 1'b0; sram_rdata = 16'h0; io_in = 16'h0;
    @(posedge clk); #1;
    chk("reset halt gated", {15'h0, halt2}, 16'h0000);
    chk("reset rdata", rd2, 16'h0000);
    chk("reset ce_n", {15'h0, ce2}, 16'h0001);
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 2);

    clr_cnt();
    drive(1'b1, 16'hFFFF, 16'hA5A5, 1'b1, 1);
    chk("io store io_out", io2, 16'hA5A5);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1);
    chk("io store no halt", 16'(hc[0] + hc[1]), 16'd0);
    chk("io store no strobe", 16'(oc[0] + wc[0]), 16'd0);

    clr_cnt();
    io_in = 16'h0F0F;
    drive(1'b1, 16'hFFFF, 16'h0, 1'b0, 1);
    chk("io load rdata", rd2, 16'h0F0F);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1);
    chk("io load no halt", 16'(hc[0]), 16'd0);

    clr_cnt();
    drive(1'b1, 16'h0020, 16'h1234, 1'b1, 1);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 5);
    chk("store halt ws2", 16'(hc[0]), 16'd3);
    chk("store halt ws1", 16'(hc[1]), 16'd2);
    chk("store we ws2", 16'(wc[0]), 16'd2);
    chk("store we ws1", 16'(wc[1]), 16'd1);
    chk("store sram_addr", sa2, 16'h0020);
    chk("store sram_wdata", sw2, 16'h1234);
    chk("store keeps rdata", rd2, 16'h0F0F);

    clr_cnt();
    sram_rdata = 16'hBEEF;
    drive(1'b1, 16'h0020, 16'h0, 1'b0, 1);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 5);
    chk("load rdata ws2", rd2, 16'hBEEF);
    chk("load rdata ws1", rd1, 16'hBEEF);
    chk("load halt ws2", 16'(hc[0]), 16'd3);
    chk("load oe ws2", 16'(oc[0]), 16'd2);
    chk("load oe ws1", 16'(oc[1]), 16'd1);
    chk("load no we", 16'(wc[0] + wc[1]), 16'd0);

    clr_cnt();
    sram_rdata = 16'h1357;
    drive(1'b1, 16'h0001, 16'h0, 1'b0, 4);
    drive(1'b1, 16'h0002, 16'hCAFE, 1'b1, 1);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 6);
    chk("b2b oe ws2", 16'(oc[0]), 16'd2);
    chk("b2b we ws2", 16'(wc[0]), 16'd2);
    chk("b2b sram_addr ws2", sa2, 16'h0002);
    chk("b2b rdata ws2", rd2, 16'h1357);
    chk("b2b oe ws1", 16'(oc[1]), 16'd2);
    chk("b2b we ws1", 16'(wc[1]), 16'd0);

    drive(1'b1, 16'h0010, 16'h7777, 1'b1, 1);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 0);
    chk("pre-reset we_n", {15'h0, we2}, 16'h0000);
    chk("pre-reset wdata", sw2, 16'h7777);
    rst = 1'b1;
    #1;
    chk("mid reset we_n", {15'h0, we2}, 16'h0001);
    chk("mid reset ce_n", {15'h0, ce2}, 16'h0001);
    chk("mid reset halt", {15'h0, halt2}, 16'h0000);
    chk("mid reset io_out", io2, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 3);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
